// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: sequences fetch, decode, execute,
// memory and writeback; drives datapath enables, mux selects, ALU op.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   opcode, funct       instruction fields from IR
//   zero                ALU zero flag (gates branch PC write)
//   memPronto           shared memory finished current access
//   pcEscreve .. pcFonte  datapath enables and mux selects
//   unidadeControle     ALU op (0 AND,1 OR,2 ADD,3 SUB,4 SLT,5 NOR)
//   estado              current state (debug)
//   instrInvalida       pulse in decode on unsupported instruction
module controle_multiciclo #(
  parameter int LARGURA_ESTADO = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      zero,
  input  logic                      memPronto,
  output logic                      pcEscreve,
  output logic                      iouD,
  output logic                      memLe,
  output logic                      memEscreve,
  output logic                      irEscreve,
  output logic                      regDst,
  output logic                      memParaReg,
  output logic                      regEscreve,
  output logic                      aluFonteA,
  output logic [1:0]                aluFonteB,
  output logic [1:0]                pcFonte,
  output logic [3:0]                unidadeControle,
  output logic [LARGURA_ESTADO-1:0] estado,
  output logic                      instrInvalida
);

  typedef enum logic [LARGURA_ESTADO-1:0] {
    BUSCA        = LARGURA_ESTADO'(0),
    DECODIFICA   = LARGURA_ESTADO'(1),
    CALC_END     = LARGURA_ESTADO'(2),
    LE_MEM       = LARGURA_ESTADO'(3),
    ESCRITA_MEM  = LARGURA_ESTADO'(4),
    ESCREVE_MEM  = LARGURA_ESTADO'(5),
    EXEC_R       = LARGURA_ESTADO'(6),
    ESCRITA_R    = LARGURA_ESTADO'(7),
    DESVIO       = LARGURA_ESTADO'(8),
    SALTO        = LARGURA_ESTADO'(9),
    EXEC_ADDI    = LARGURA_ESTADO'(10),
    ESCRITA_ADDI = LARGURA_ESTADO'(11)
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  estado_t     r_estado;
  estado_t     w_prox;
  logic [3:0]  w_aluR;
  logic        w_functOk;

  // R-type funct decode shared by decode (validity) and execute (ALU op)
  always_comb begin
    w_functOk = 1'b1;
    w_aluR    = 4'd2;
    case (funct)
      6'b100000: w_aluR = 4'd2;
      6'b100010: w_aluR = 4'd3;
      6'b100100: w_aluR = 4'd0;
      6'b100101: w_aluR = 4'd1;
      6'b101010: w_aluR = 4'd4;
      6'b100111: w_aluR = 4'd5;
      default:   w_functOk = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_estado <= BUSCA;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox          = BUSCA;
    pcEscreve       = 1'b0;
    iouD            = 1'b0;
    memLe           = 1'b0;
    memEscreve      = 1'b0;
    irEscreve       = 1'b0;
    regDst          = 1'b0;
    memParaReg      = 1'b0;
    regEscreve      = 1'b0;
    aluFonteA       = 1'b0;
    aluFonteB       = 2'b00;
    pcFonte         = 2'b00;
    unidadeControle = 4'd2;
    instrInvalida   = 1'b0;
    case (r_estado)
      BUSCA: begin
        memLe     = 1'b1;
        aluFonteB = 2'b01;
        irEscreve = memPronto;
        pcEscreve = memPronto;
        w_prox    = memPronto ? DECODIFICA : BUSCA;
      end
      DECODIFICA: begin
        // branch target is precomputed here into ALUOut
        aluFonteB = 2'b11;
        unique case (1'b1)
          (opcode == OP_R) && w_functOk: w_prox = EXEC_R;
          (opcode == OP_LW),
          (opcode == OP_SW):             w_prox = CALC_END;
          (opcode == OP_BEQ):            w_prox = DESVIO;
          (opcode == OP_J):              w_prox = SALTO;
          (opcode == OP_ADDI):           w_prox = EXEC_ADDI;
          default:                       instrInvalida = 1'b1;
        endcase
      end
      CALC_END: begin
        aluFonteA = 1'b1;
        aluFonteB = 2'b10;
        w_prox    = (opcode == OP_LW) ? LE_MEM : ESCREVE_MEM;
      end
      LE_MEM: begin
        iouD   = 1'b1;
        memLe  = 1'b1;
        w_prox = memPronto ? ESCRITA_MEM : LE_MEM;
      end
      ESCRITA_MEM: begin
        memParaReg = 1'b1;
        regEscreve = 1'b1;
      end
      ESCREVE_MEM: begin
        iouD       = 1'b1;
        memEscreve = 1'b1;
        w_prox     = memPronto ? BUSCA : ESCREVE_MEM;
      end
      EXEC_R: begin
        aluFonteA       = 1'b1;
        unidadeControle = w_aluR;
        w_prox          = ESCRITA_R;
      end
      ESCRITA_R: begin
        regDst     = 1'b1;
        regEscreve = 1'b1;
      end
      DESVIO: begin
        aluFonteA       = 1'b1;
        unidadeControle = 4'd3;
        pcFonte         = 2'b01;
        pcEscreve       = zero;
      end
      SALTO: begin
        pcFonte   = 2'b10;
        pcEscreve = 1'b1;
      end
      EXEC_ADDI: begin
        aluFonteA = 1'b1;
        aluFonteB = 2'b10;
        w_prox    = ESCRITA_ADDI;
      end
      ESCRITA_ADDI: regEscreve = 1'b1;
      default: ;
    endcase
    // reset suppresses every side effect of the current state
    if (reset) begin
      pcEscreve     = 1'b0;
      memLe         = 1'b0;
      memEscreve    = 1'b0;
      irEscreve     = 1'b0;
      regEscreve    = 1'b0;
      instrInvalida = 1'b0;
    end
  end

  assign estado = r_estado;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: per-instruction cycle
// traces built from the instruction class, compared every cycle.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memPronto = 1'b0;
  logic       pcEscreve, iouD, memLe, memEscreve, irEscreve;
  logic       regDst, memParaReg, regEscreve, aluFonteA;
  logic [1:0] aluFonteB, pcFonte;
  logic [3:0] unidadeControle;
  logic [3:0] estado;
  logic       instrInvalida;

  always #5 clock = ~clock;

  controle_multiciclo #(.LARGURA_ESTADO(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .memPronto(memPronto), .pcEscreve(pcEscreve),
    .iouD(iouD), .memLe(memLe), .memEscreve(memEscreve),
    .irEscreve(irEscreve), .regDst(regDst), .memParaReg(memParaReg),
    .regEscreve(regEscreve), .aluFonteA(aluFonteA),
    .aluFonteB(aluFonteB), .pcFonte(pcFonte),
    .unidadeControle(unidadeControle), .estado(estado),
    .instrInvalida(instrInvalida)
  );

  int total = 0;
  int bad = 0;
  int n_cyc, n_regE, n_pcE, n_inv, n_memLe;
  int last_ula;
  bit chk = 0;
  logic [21:0] exp_v;

  wire [21:0] act_v = {estado, pcEscreve, iouD, memLe, memEscreve,
                       irEscreve, regDst, memParaReg, regEscreve,
                       aluFonteA, aluFonteB, pcFonte, unidadeControle,
                       instrInvalida};

  // R-type funct table: funct -> ALU op, -1 when unsupported
  function automatic int ula_de(input logic [5:0] fn);
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    int ops [6] = '{2, 3, 0, 1, 4, 5};
    for (int i = 0; i < 6; i++)
      if (fns[i] == fn) return ops[i];
    return -1;
  endfunction

  // Output table for one cycle, from the state's listed outputs
  function automatic logic [21:0] modelo(input int st, input bit rst,
      input bit mp, input bit z, input logic [5:0] fn, input bit inv);
    logic pe = 0, io = 0, ml = 0, me = 0, ie = 0, rd = 0, mr = 0, re = 0;
    logic aa = 0;
    logic [1:0] ab = 0, pf = 0;
    logic [3:0] u = 4'd2;
    logic iv = 0;
    case (st)
      0: begin ml = 1; ab = 2'b01; ie = mp; pe = mp; end
      1: begin ab = 2'b11; iv = inv; end
      2: begin aa = 1; ab = 2'b10; end
      3: begin io = 1; ml = 1; end
      4: begin mr = 1; re = 1; end
      5: begin io = 1; me = 1; end
      6: begin aa = 1; u = 4'(ula_de(fn)); end
      7: begin rd = 1; re = 1; end
      8: begin aa = 1; u = 4'd3; pf = 2'b01; pe = z; end
      9: begin pf = 2'b10; pe = 1; end
      10: begin aa = 1; ab = 2'b10; end
      11: re = 1;
      default: ;
    endcase
    if (rst) begin pe = 0; ml = 0; me = 0; ie = 0; re = 0; iv = 0; end
    return {4'(st), pe, io, ml, me, ie, rd, mr, re, aa, ab, pf, u, iv};
  endfunction

  always @(negedge clock) begin
    if (chk) begin
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle t=%0t act=%b exp=%b", $time, act_v, exp_v);
      end
      if (regEscreve) n_regE++;
      if (pcEscreve) n_pcE++;
      if (instrInvalida) n_inv++;
      if (memLe) n_memLe++;
      if (estado == 4'd6) last_ula = int'(unidadeControle);
    end
  end

  task automatic cyc(input int st, input bit rst, input bit mp,
                     input bit inv);
    reset = rst;
    memPronto = mp;
    exp_v = modelo(st, rst, mp, zero, funct, inv);
    chk = 1;
    n_cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic zera();
    n_cyc = 0; n_regE = 0; n_pcE = 0; n_inv = 0; n_memLe = 0;
    last_ula = -1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input bit z, input int bw, input int mw);
    zera();
    opcode = op;
    funct = fn;
    zero = z;
    for (int i = 0; i < bw; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    if (op == 6'h00 && ula_de(fn) >= 0) begin
      cyc(1, 0, 1, 0); cyc(6, 0, 1, 0); cyc(7, 0, 1, 0);
    end else if (op == 6'h23) begin
      cyc(1, 0, 1, 0); cyc(2, 0, 1, 0);
      for (int i = 0; i < mw; i++) cyc(3, 0, 0, 0);
      cyc(3, 0, 1, 0); cyc(4, 0, 1, 0);
    end else if (op == 6'h2b) begin
      cyc(1, 0, 1, 0); cyc(2, 0, 1, 0);
      for (int i = 0; i < mw; i++) cyc(5, 0, 0, 0);
      cyc(5, 0, 1, 0);
    end else if (op == 6'h04) begin
      cyc(1, 0, 1, 0); cyc(8, 0, 1, 0);
    end else if (op == 6'h02) begin
      cyc(1, 0, 1, 0); cyc(9, 0, 1, 0);
    end else if (op == 6'h08) begin
      cyc(1, 0, 1, 0); cyc(10, 0, 1, 0); cyc(11, 0, 1, 0);
    end else begin
      cyc(1, 0, 1, 1);
    end
  endtask

  initial begin
    zera();
    @(posedge clock);
    #1;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    lit("reset_no_writes", n_pcE + n_regE + n_memLe, 0);

    instr(6'h00, 6'h20, 0, 0, 0);
    lit("add_latency", n_cyc, 4);
    lit("add_regE", n_regE, 1);
    lit("add_ula", last_ula, 2);

    instr(6'h23, 6'h00, 0, 2, 3);
    lit("lw_latency", n_cyc, 10);
    lit("lw_memLe_cycles", n_memLe, 7);
    lit("lw_pcE", n_pcE, 1);
    lit("lw_regE", n_regE, 1);

    instr(6'h04, 6'h00, 1, 0, 0);
    lit("beq_taken_pcE", n_pcE, 2);
    lit("beq_latency", n_cyc, 3);
    instr(6'h04, 6'h00, 0, 0, 0);
    lit("beq_not_taken_pcE", n_pcE, 1);

    instr(6'h00, 6'h22, 0, 0, 0); lit("sub_ula", last_ula, 3);
    instr(6'h00, 6'h24, 0, 0, 0); lit("and_ula", last_ula, 0);
    instr(6'h00, 6'h25, 0, 0, 0); lit("or_ula", last_ula, 1);
    instr(6'h00, 6'h2a, 0, 0, 0); lit("slt_ula", last_ula, 4);
    instr(6'h00, 6'h27, 0, 0, 0); lit("nor_ula", last_ula, 5);

    instr(6'h00, 6'h08, 0, 0, 0);
    lit("badfunct_inv", n_inv, 1);
    lit("badfunct_regE", n_regE, 0);
    lit("badfunct_latency", n_cyc, 2);

    instr(6'h2b, 6'h00, 0, 0, 1);
    lit("sw_latency", n_cyc, 5);
    lit("sw_regE", n_regE, 0);

    instr(6'h02, 6'h00, 0, 0, 0);
    lit("j_latency", n_cyc, 3);
    instr(6'h08, 6'h00, 0, 0, 0);
    lit("addi_latency", n_cyc, 4);
    lit("addi_regE", n_regE, 1);

    // lw abandoned by reset while waiting on memory
    zera();
    opcode = 6'h23;
    funct = 6'h00;
    cyc(0, 0, 1, 0); cyc(1, 0, 1, 0); cyc(2, 0, 1, 0);
    cyc(3, 0, 0, 0); cyc(3, 1, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    lit("lw_reset_regE", n_regE, 0);

    instr(6'h3f, 6'h00, 0, 0, 0);
    lit("badop_inv", n_inv, 1);
    cyc(0, 0, 0, 0);

    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
